// File: rtl/muldiv_if.sv
// Handshake bundle between the execute stage and the iterative multiply/divide unit.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             kill;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Out;

  modport master (output in_valid, op, A, B, kill, out_ready,
                  input  in_ready, out_valid, Out);
  modport slave  (input  in_valid, op, A, B, kill, out_ready,
                  output in_ready, out_valid, Out);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: one result bit per cycle on operand magnitudes,
// then a single fix-up cycle for sign and special cases. Fixed WIDTH+1 cycle latency.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic    clk,
  input  logic    rst,
  muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mc;      // multiplicand (mul) or divisor (div) magnitude
  logic [WIDTH-1:0] hi, lo;  // product halves, or remainder / quotient
  logic             in_ready_q, out_valid_q;
  logic [WIDTH-1:0] out_q;

  logic             sa, sb, an_v, bn_v;
  logic [WIDTH-1:0] ma_v, mb_v;
  always_comb begin
    sa   = (bus.op == 3'd1) || (bus.op == 3'd2) || (bus.op == 3'd4) || (bus.op == 3'd6);
    sb   = (bus.op == 3'd1) || (bus.op == 3'd4) || (bus.op == 3'd6);
    an_v = sa & bus.A[WIDTH-1];
    bn_v = sb & bus.B[WIDTH-1];
    ma_v = an_v ? -bus.A : bus.A;
    mb_v = bn_v ? -bus.B : bus.B;
  end

  logic [WIDTH:0]     sum, shifted, diff;
  logic [2*WIDTH-1:0] prod, prod_n;
  logic               div0, ovf;
  logic [WIDTH-1:0]   res;
  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, mc} : '0);
    shifted = {hi, lo[WIDTH-1]};
    diff    = shifted - {1'b0, mc};
    prod    = {hi, lo};
    prod_n  = (a_neg ^ b_neg) ? -prod : prod;
    div0    = (b_q == '0);
    ovf     = (a_q == MINV) && (b_q == '1);
    res     = '0;
    case (op_q)
      3'd0:                   res = prod_n[WIDTH-1:0];
      3'd1, 3'd2, 3'd3:       res = prod_n[2*WIDTH-1:WIDTH];
      3'd4: res = div0 ? '1  : ovf ? a_q : ((a_neg ^ b_neg) ? -lo : lo);
      3'd5: res = div0 ? '1  : lo;
      3'd6: res = div0 ? a_q : ovf ? '0  : (a_neg ? -hi : hi);
      default: res = div0 ? a_q : hi;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      a_neg       <= 1'b0;
      b_neg       <= 1'b0;
      mc          <= '0;
      hi          <= '0;
      lo          <= '0;
    end else if (bus.kill) begin
      state       <= IDLE;
      cnt         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          op_q       <= bus.op;
          a_q        <= bus.A;
          b_q        <= bus.B;
          a_neg      <= an_v;
          b_neg      <= bn_v;
          mc         <= bus.op[2] ? mb_v : ma_v;
          lo         <= bus.op[2] ? ma_v : mb_v;
          hi         <= '0;
          cnt        <= '0;
          in_ready_q <= 1'b0;
          state      <= CALC;
        end
        CALC: begin
          if (op_q[2]) begin
            // restoring step: keep the trial difference unless it borrowed
            if (!diff[WIDTH]) begin
              hi <= diff[WIDTH-1:0];
              lo <= {lo[WIDTH-2:0], 1'b1};
            end else begin
              hi <= shifted[WIDTH-1:0];
              lo <= {lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            hi <= sum[WIDTH:1];
            lo <= {sum[0], lo[WIDTH-1:1]};
          end
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          out_q       <= res;
          out_valid_q <= 1'b1;
          state       <= DONE;
        end
        default: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.Out       = out_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH=32) with hand-computed RV32M results.
module tb_muldiv_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  muldiv_if #(.WIDTH(W)) bus ();
  muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for in_ready, then present one request for exactly one edge.
  task automatic start(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    for (int i = 0; i < 50 && !bus.in_ready; i++) step();
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.A  = a;
    bus.B  = b;
    step();
    bus.in_valid = 1'b0;
    bus.A = 32'hDEAD_BEEF;
    bus.B = 32'h1234_5678;
    bus.op = ~op;
  endtask

  // Returns the edge count from accept to first out_valid (-1 on timeout).
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat, output logic [W-1:0] res, output bit ir_seen);
    start(op, a, b);
    lat = -1;
    ir_seen = 0;
    for (int i = 1; i <= 100; i++) begin
      if (bus.in_ready) ir_seen = 1;
      step();
      if (bus.out_valid) begin
        lat = i;
        break;
      end
    end
    res = bus.Out;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_chk++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.Out !== '0) begin
      n_fail++;
      $display("FAIL reset: in_ready=%b out_valid=%b Out=%h, want 1 0 0", bus.in_ready, bus.out_valid, bus.Out);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_mul_basic();
    int lat; logic [W-1:0] r; bit irs;
    bus.out_ready = 1'b1;
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, lat, r, irs);
    n_chk++;
    if (r !== 32'hFFFF_FFEB) begin
      n_fail++; $display("FAIL mul_basic value: got %h want ffffffeb", r);
    end
    n_chk++;
    if (lat !== W + 1) begin
      n_fail++; $display("FAIL mul_basic latency: got %0d want %0d", lat, W + 1);
    end
    n_chk++;
    if (irs || bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL mul_basic in_ready busy: seen=%b now=%b want 0 0", irs, bus.in_ready);
    end
    step();
    n_chk++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL mul_basic release: out_valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic run_table(input string tag, input logic [2:0] ops[], input logic [W-1:0] as[],
                           input logic [W-1:0] bs[], input logic [W-1:0] exps[]);
    int lat; logic [W-1:0] r; bit irs;
    bus.out_ready = 1'b1;
    for (int i = 0; i < ops.size(); i++) begin
      issue(ops[i], as[i], bs[i], lat, r, irs);
      n_chk++;
      if (r !== exps[i] || lat !== W + 1) begin
        n_fail++;
        $display("FAIL %s[%0d] op=%0d A=%h B=%h: got %h lat %0d, want %h lat %0d",
                 tag, i, ops[i], as[i], bs[i], r, lat, exps[i], W + 1);
      end
      step();
    end
  endtask

  task automatic test_mul_high();
    run_table("mul_high", '{3'd1, 3'd3, 3'd2, 3'd0},
              '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
              '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
              '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0001});
  endtask

  task automatic test_divide();
    run_table("divide", '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6},
              '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd7, 32'd7},
              '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFE},
              '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFD, 32'd1});
  endtask

  task automatic test_special();
    run_table("special", '{3'd4, 3'd6, 3'd5, 3'd4, 3'd6, 3'd7},
              '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000},
              '{32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0},
              '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32'h8000_0000});
  endtask

  task automatic test_back_to_back();
    int lat; logic [W-1:0] r; bit irs;
    bus.out_ready = 1'b0;
    issue(3'd5, 32'd1000, 32'd10, lat, r, irs);
    n_chk++;
    if (r !== 32'd100 || lat !== W + 1) begin
      n_fail++; $display("FAIL backpressure first: got %h lat %0d want 00000064 lat %0d", r, lat, W + 1);
    end
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      bus.op = 3'd0;
      bus.A = 32'd9;
      bus.B = 32'd9;
      step();
      n_chk++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.Out !== 32'd100) begin
        n_fail++;
        $display("FAIL backpressure hold[%0d]: out_valid=%b in_ready=%b Out=%h want 1 0 00000064",
                 i, bus.out_valid, bus.in_ready, bus.Out);
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    step();
    n_chk++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL backpressure release: out_valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready);
    end
    issue(3'd5, 32'd81, 32'd9, lat, r, irs);
    n_chk++;
    if (r !== 32'd9 || lat !== W + 1) begin
      n_fail++; $display("FAIL backpressure next: got %h lat %0d want 00000009 lat %0d", r, lat, W + 1);
    end
    step();
  endtask

  task automatic test_kill();
    int lat; logic [W-1:0] r; bit irs; bit seen;
    bus.out_ready = 1'b1;
    start(3'd0, 32'd1234, 32'd5678);
    for (int i = 1; i < 10; i++) step();
    bus.kill = 1'b1;
    step();
    bus.kill = 1'b0;
    n_chk++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL kill abort: in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.out_valid) seen = 1;
    end
    n_chk++;
    if (seen) begin
      n_fail++; $display("FAIL kill no_result: out_valid seen=1 want 0");
    end
    issue(3'd0, 32'd3, 32'd4, lat, r, irs);
    n_chk++;
    if (r !== 32'd12 || lat !== W + 1) begin
      n_fail++; $display("FAIL kill next: got %h lat %0d want 0000000c lat %0d", r, lat, W + 1);
    end
    step();
  endtask

  task automatic test_rst_done();
    int lat; logic [W-1:0] r; bit irs;
    bus.out_ready = 1'b0;
    issue(3'd4, 32'd20, 32'd3, lat, r, irs);
    n_chk++;
    if (r !== 32'd6 || bus.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL rst_done pre: got %h out_valid=%b want 00000006 1", r, bus.out_valid);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_chk++;
    if (bus.out_valid !== 1'b0 || bus.Out !== '0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_done: out_valid=%b Out=%h in_ready=%b want 0 0 1", bus.out_valid, bus.Out, bus.in_ready);
    end
    bus.out_ready = 1'b1;
  endtask

  task automatic test_kill_idle();
    bit seen;
    bus.in_valid = 1'b1;
    bus.kill = 1'b1;
    bus.op = 3'd0;
    bus.A = 32'd2;
    bus.B = 32'd2;
    step();
    bus.in_valid = 1'b0;
    bus.kill = 1'b0;
    n_chk++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL kill_idle accept: in_ready=%b want 1", bus.in_ready);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.out_valid || !bus.in_ready) seen = 1;
    end
    n_chk++;
    if (seen) begin
      n_fail++; $display("FAIL kill_idle busy: unit left IDLE, want no activity");
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.op = 3'd0;
    bus.A = '0;
    bus.B = '0;
    bus.kill = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_mul_basic();
    test_mul_high();
    test_divide();
    test_special();
    test_back_to_back();
    test_kill();
    test_rst_done();
    test_kill_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
